// File: rtl/phase_accumulator_glide_pkg.sv
// rtl/phase_accumulator_glide_pkg.sv - shared width defaults for the oscillator voice
package phase_accumulator_glide_pkg;
  // Tone generators import these so their phase inputs match the accumulator width.
  localparam int DEFAULT_ACCUMULATOR_BITS = 24;
  localparam int DEFAULT_FREQ_BITS        = 16;
  localparam int DEFAULT_GLIDE_BITS       = 8;
endpackage

// File: rtl/phase_accumulator_glide_freq_slew_limiter.sv
// rtl/phase_accumulator_glide_freq_slew_limiter.sv - next effective increment, slewed toward target
module phase_accumulator_glide_freq_slew_limiter
  import phase_accumulator_glide_pkg::*;
#(
  parameter int FREQ_BITS  = DEFAULT_FREQ_BITS,
  parameter int GLIDE_BITS = DEFAULT_GLIDE_BITS
) (
  input  logic [FREQ_BITS-1:0]  cur_freq,
  input  logic [FREQ_BITS-1:0]  tone_freq,
  input  logic [GLIDE_BITS-1:0] glide_rate,
  output logic [FREQ_BITS-1:0]  next_freq
);

  logic [FREQ_BITS:0] rate_ext;
  logic [FREQ_BITS:0] up_sum;
  logic [FREQ_BITS:0] down_diff;

  assign rate_ext = {{(FREQ_BITS + 1 - GLIDE_BITS){1'b0}}, glide_rate};

  // One extra bit so a step past full scale or below zero is seen and clamped to the target.
  always_comb begin
    up_sum    = {1'b0, cur_freq} + rate_ext;
    down_diff = {1'b0, cur_freq} - rate_ext;
    next_freq = cur_freq;
    if (glide_rate == '0) begin
      next_freq = tone_freq;
    end else if (cur_freq < tone_freq) begin
      next_freq = (up_sum > {1'b0, tone_freq}) ? tone_freq : up_sum[FREQ_BITS-1:0];
    end else if (cur_freq > tone_freq) begin
      next_freq = (down_diff[FREQ_BITS] || (down_diff[FREQ_BITS-1:0] < tone_freq))
                  ? tone_freq : down_diff[FREQ_BITS-1:0];
    end
  end

endmodule

// File: rtl/phase_accumulator_glide.sv
// rtl/phase_accumulator_glide.sv - per-voice phase accumulator with glide and hard sync
module phase_accumulator_glide
  import phase_accumulator_glide_pkg::*;
#(
  parameter int ACCUMULATOR_BITS = DEFAULT_ACCUMULATOR_BITS,
  parameter int FREQ_BITS        = DEFAULT_FREQ_BITS,
  parameter int GLIDE_BITS       = DEFAULT_GLIDE_BITS
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        sample_en,
  input  logic [FREQ_BITS-1:0]        tone_freq,
  input  logic [GLIDE_BITS-1:0]       glide_rate,
  input  logic                        sync_in,
  output logic [ACCUMULATOR_BITS-1:0] accumulator,
  output logic [FREQ_BITS-1:0]        cur_freq,
  output logic                        sync_out,
  output logic                        gliding
);

  logic                      sync_pending;
  logic [FREQ_BITS-1:0]      next_freq;
  logic [ACCUMULATOR_BITS:0] phase_sum;

  phase_accumulator_glide_freq_slew_limiter #(
    .FREQ_BITS  (FREQ_BITS),
    .GLIDE_BITS (GLIDE_BITS)
  ) u_slew (
    .cur_freq   (cur_freq),
    .tone_freq  (tone_freq),
    .glide_rate (glide_rate),
    .next_freq  (next_freq)
  );

  // The top bit of the sum is the wrap carry that drives sync_out.
  assign phase_sum = {1'b0, accumulator}
                   + {{(ACCUMULATOR_BITS + 1 - FREQ_BITS){1'b0}}, cur_freq};

  assign gliding = (cur_freq != tone_freq);

  always_ff @(posedge clk) begin
    if (rst) begin
      accumulator  <= '0;
      cur_freq     <= '0;
      sync_out     <= 1'b0;
      sync_pending <= 1'b0;
    end else if (sample_en) begin
      if (sync_in || sync_pending) begin
        accumulator <= '0;
        sync_out    <= 1'b0;
      end else begin
        accumulator <= phase_sum[ACCUMULATOR_BITS-1:0];
        sync_out    <= phase_sum[ACCUMULATOR_BITS];
      end
      cur_freq     <= next_freq;
      sync_pending <= 1'b0;
    end else begin
      sync_out <= 1'b0;
      if (sync_in) begin
        sync_pending <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_phase_accumulator_glide.sv
// tb/tb_phase_accumulator_glide.sv - scoreboard bench for phase_accumulator_glide
module tb_phase_accumulator_glide;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        sample_en = 1'b0;
  logic [15:0] tone_freq = '0;
  logic [7:0]  glide_rate = '0;
  logic        sync_in = 1'b0;
  logic [23:0] accumulator;
  logic [15:0] cur_freq;
  logic        sync_out;
  logic        gliding;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  typedef struct {
    string       name;
    int          cyc;
    logic [23:0] acc;
    logic [15:0] cur;
    logic        so;
    logic        gl;
  } exp_t;

  exp_t sb[$];

  phase_accumulator_glide #(
    .ACCUMULATOR_BITS (24),
    .FREQ_BITS        (16),
    .GLIDE_BITS       (8)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .sample_en   (sample_en),
    .tone_freq   (tone_freq),
    .glide_rate  (glide_rate),
    .sync_in     (sync_in),
    .accumulator (accumulator),
    .cur_freq    (cur_freq),
    .sync_out    (sync_out),
    .gliding     (gliding)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Drive at the falling edge, let one rising edge happen, stop just after it.
  task automatic tick(input logic se, input logic [15:0] tf, input logic [7:0] gr,
                      input logic si, input logic r);
    @(negedge clk);
    sample_en  = se;
    tone_freq  = tf;
    glide_rate = gr;
    sync_in    = si;
    rst        = r;
    @(posedge clk);
    #1;
  endtask

  task automatic expect_state(input string nm, input logic [23:0] a, input logic [15:0] c,
                              input logic so, input logic gl);
    exp_t e;
    e.name = nm;
    e.cyc  = cyc;
    e.acc  = a;
    e.cur  = c;
    e.so   = so;
    e.gl   = gl;
    sb.push_back(e);
  endtask

  task automatic cmp(input string nm, input string field, input logic [23:0] act,
                     input logic [23:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s.%s actual=%h required=%h", nm, field, act, req);
    end
  endtask

  always @(posedge clk) begin
    #3;
    while (sb.size() > 0 && sb[0].cyc <= cyc) begin
      exp_t e;
      e = sb.pop_front();
      cmp(e.name, "accumulator", accumulator, e.acc);
      cmp(e.name, "cur_freq", {8'h00, cur_freq}, {8'h00, e.cur});
      cmp(e.name, "sync_out", {23'h0, sync_out}, {23'h0, e.so});
      cmp(e.name, "gliding", {23'h0, gliding}, {23'h0, e.gl});
    end
  end

  initial begin
    // Reset and steady run
    tick(0, 16'h1000, 8'h00, 0, 1); expect_state("reset", 24'h0, 16'h0, 0, 1);
    tick(1, 16'h1000, 8'h00, 0, 0); expect_state("run_t1", 24'h0, 16'h1000, 0, 0);
    tick(1, 16'h1000, 8'h00, 0, 0); expect_state("run_t2", 24'h001000, 16'h1000, 0, 0);
    tick(1, 16'h1000, 8'h00, 0, 0); expect_state("run_t3", 24'h002000, 16'h1000, 0, 0);
    tick(1, 16'h1000, 8'h00, 0, 0); expect_state("run_t4", 24'h003000, 16'h1000, 0, 0);

    // Wrap
    tick(0, 16'hFFFF, 8'h00, 0, 1); expect_state("wrap_rst", 24'h0, 16'h0, 0, 1);
    for (int i = 1; i <= 256; i++) tick(1, 16'hFFFF, 8'h00, 0, 0);
    tick(1, 16'hFFFF, 8'h00, 0, 0); expect_state("wrap_t257", 24'hFFFF00, 16'hFFFF, 0, 0);
    tick(1, 16'hFFFF, 8'h00, 0, 0); expect_state("wrap_t258", 24'h00FEFF, 16'hFFFF, 1, 0);
    tick(1, 16'hFFFF, 8'h00, 0, 0); expect_state("wrap_t259", 24'h01FEFE, 16'hFFFF, 0, 0);
    tick(0, 16'hFFFF, 8'h00, 0, 0); expect_state("wrap_idle", 24'h01FEFE, 16'hFFFF, 0, 0);

    // Glide up then down
    tick(0, 16'h0100, 8'h30, 0, 1); expect_state("glide_rst", 24'h0, 16'h0, 0, 1);
    tick(1, 16'h0100, 8'h30, 0, 0); expect_state("up1", 24'h000000, 16'h0030, 0, 1);
    tick(1, 16'h0100, 8'h30, 0, 0); expect_state("up2", 24'h000030, 16'h0060, 0, 1);
    tick(1, 16'h0100, 8'h30, 0, 0); expect_state("up3", 24'h000090, 16'h0090, 0, 1);
    tick(1, 16'h0100, 8'h30, 0, 0); expect_state("up4", 24'h000120, 16'h00C0, 0, 1);
    tick(1, 16'h0100, 8'h30, 0, 0); expect_state("up5", 24'h0001E0, 16'h00F0, 0, 1);
    tick(1, 16'h0100, 8'h30, 0, 0); expect_state("up6", 24'h0002D0, 16'h0100, 0, 0);
    tick(1, 16'h0020, 8'h30, 0, 0); expect_state("dn1", 24'h0003D0, 16'h00D0, 0, 1);
    tick(1, 16'h0020, 8'h30, 0, 0); expect_state("dn2", 24'h0004A0, 16'h00A0, 0, 1);
    tick(1, 16'h0020, 8'h30, 0, 0); expect_state("dn3", 24'h000540, 16'h0070, 0, 1);
    tick(1, 16'h0020, 8'h30, 0, 0); expect_state("dn4", 24'h0005B0, 16'h0040, 0, 1);
    tick(1, 16'h0020, 8'h30, 0, 0); expect_state("dn5", 24'h0005F0, 16'h0020, 0, 0);
    tick(1, 16'h0020, 8'h30, 0, 0); expect_state("dn_hold", 24'h000610, 16'h0020, 0, 0);

    // Build accumulator = 0x123456, then sync latch
    tick(0, 16'h0056, 8'h00, 0, 1); expect_state("sync_rst", 24'h0, 16'h0, 0, 1);
    tick(1, 16'h0056, 8'h00, 0, 0); expect_state("pre1", 24'h000000, 16'h0056, 0, 0);
    tick(1, 16'h1234, 8'h00, 0, 0); expect_state("pre2", 24'h000056, 16'h1234, 0, 0);
    for (int i = 0; i < 256; i++) tick(1, 16'h1234, 8'h00, 0, 0);
    expect_state("pre_done", 24'h123456, 16'h1234, 0, 0);
    tick(0, 16'h1234, 8'h00, 1, 0); expect_state("sync_pulse", 24'h123456, 16'h1234, 0, 0);
    tick(0, 16'h1234, 8'h00, 0, 0);
    tick(0, 16'h1234, 8'h00, 0, 0); expect_state("sync_wait", 24'h123456, 16'h1234, 0, 0);
    tick(1, 16'h1234, 8'h00, 0, 0); expect_state("sync_apply", 24'h000000, 16'h1234, 0, 0);
    tick(1, 16'h1234, 8'h00, 0, 0); expect_state("sync_resume", 24'h001234, 16'h1234, 0, 0);
    tick(0, 16'h1234, 8'h00, 1, 0);
    tick(0, 16'h1234, 8'h00, 1, 0);
    tick(1, 16'h1234, 8'h00, 0, 0); expect_state("sync_multi", 24'h000000, 16'h1234, 0, 0);
    tick(1, 16'h1234, 8'h00, 0, 0); expect_state("multi_resume", 24'h001234, 16'h1234, 0, 0);
    tick(1, 16'h1234, 8'h00, 1, 0); expect_state("sync_coinc", 24'h000000, 16'h1234, 0, 0);
    tick(1, 16'h1234, 8'h00, 0, 0); expect_state("coinc_resume", 24'h001234, 16'h1234, 0, 0);

    // Hold with sample_en low while target changes
    tick(1, 16'h1000, 8'h00, 0, 0); expect_state("hold_pre", 24'h002468, 16'h1000, 0, 0);
    tick(0, 16'h2000, 8'h00, 0, 0); expect_state("hold_first", 24'h002468, 16'h1000, 0, 1);
    for (int i = 0; i < 9; i++) tick(0, 16'h2000, 8'h00, 0, 0);
    expect_state("hold_last", 24'h002468, 16'h1000, 0, 1);
    tick(1, 16'h2000, 8'h00, 0, 0); expect_state("hold_release", 24'h003468, 16'h2000, 0, 0);

    // Reset mid-glide with a pending sync
    tick(1, 16'h3000, 8'h10, 0, 0); expect_state("mid_glide", 24'h005468, 16'h2010, 0, 1);
    tick(0, 16'h3000, 8'h10, 1, 0); expect_state("mid_pend", 24'h005468, 16'h2010, 0, 1);
    tick(0, 16'h3000, 8'h10, 0, 1); expect_state("mid_rst", 24'h000000, 16'h0000, 0, 1);
    tick(1, 16'h3000, 8'h10, 0, 0); expect_state("post_rst1", 24'h000000, 16'h0010, 0, 1);
    tick(1, 16'h3000, 8'h10, 0, 0); expect_state("post_rst2", 24'h000010, 16'h0020, 0, 1);

    repeat (3) @(posedge clk);
    #5;
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain actual=%0d required=0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/phase_accumulator_glide.md
Name: phase_accumulator_glide

Overview:
- Per-voice phase accumulator with portamento (glide) and hard sync.
- Advances a phase word once per audio sample strobe; its accumulator output feeds the tone generators (pulse, saw, triangle) directly downstream.
- Slews the effective frequency toward a target at a programmable rate.
- Emits a one-cycle wrap strobe so one oscillator can hard-sync another.

Parameters:
- ACCUMULATOR_BITS, 24, width of phase accumulator.
- FREQ_BITS, 16, width of frequency increment; must be <= ACCUMULATOR_BITS.
- GLIDE_BITS, 8, width of glide step per sample.

Ports:
- clk  input  1  system clock.
- rst  input  1  reset; synchronous, active-high.
- sample_en  input  1  one-clk strobe per audio sample.
- tone_freq  input  FREQ_BITS  target phase increment.
- glide_rate  input  GLIDE_BITS  max increment change per sample; 0 = no glide.
- sync_in  input  1  hard-sync request (any cycle).
- accumulator  output  ACCUMULATOR_BITS  registered phase word to tone generators.
- cur_freq  output  FREQ_BITS  registered effective increment.
- sync_out  output  1  one-clk pulse on phase wrap.
- gliding  output  1  high while cur_freq != tone_freq.

Behaviour:
- Reset (sync, active-high, highest priority over every other input): accumulator=0, cur_freq=0, sync_out=0, sync_pending=0. gliding therefore reads 1 iff tone_freq != 0.
- sample_en low: accumulator and cur_freq hold; sync_out=0; tone_freq/glide_rate changes have no effect until the next strobe.
- On a sample_en cycle (all updates land at the next clk edge, 1-cycle latency):
  - Phase:
    - If sync_in or sync_pending: accumulator<=0, no add.
    - Else: accumulator <= accumulator + zero-extended cur_freq, using the cur_freq value before this strobe's glide update. Wraps modulo 2^ACCUMULATOR_BITS.
  - Wrap carry (bit ACCUMULATOR_BITS of the sum): sync_out<=1 for exactly one clk. A hard-sync reset does not assert sync_out.
  - Glide:
    - glide_rate==0: cur_freq<=tone_freq.
    - cur_freq<tone_freq: cur_freq<=min(cur_freq+glide_rate, tone_freq).
    - cur_freq>tone_freq: cur_freq<=max(cur_freq-glide_rate, tone_freq).
    - Equal: hold.
    - Arithmetic is FREQ_BITS+1 wide; no overflow or underflow past the target.
  - sync_pending<=0.
- Sync latch:
  - sync_in high on a non-strobe cycle sets sync_pending; it is consumed on the next strobe.
  - Multiple pulses before a strobe collapse into one sync.
  - sync_in on a strobe cycle is applied immediately; pending is not left set.
- gliding is combinational from cur_freq and tone_freq. It carries no state.
- sync_out is low on every cycle other than the one after a wrapping strobe.
- Back-to-back strobes (sample_en held high) are legal; one update per clk.

Decomposition:
- Shared package/header: default ACCUMULATOR_BITS/FREQ_BITS/GLIDE_BITS constants, shared with the tone generators so accumulator widths match.
- One sub-module is natural: freq_slew_limiter (combinational next-cur_freq from cur_freq, tone_freq, glide_rate). The accumulator, sync latch and registers stay in the top.

Test Plan:
- Run freq at ACC=24, FREQ=16: rst, tone_freq=0x1000, glide_rate=0, sample_en every clk -> after tick1: cur_freq=0x1000, accumulator=0. After tick2: 0x001000. Then +0x1000 per tick. gliding=0 after tick1.
- Wrap: tone_freq=0xFFFF, glide 0, continuous strobes -> after tick257 accumulator=0xFFFF00. After tick258 accumulator=0x00FEFF and sync_out=1 for exactly that one clk, 0 the next.
- Glide up/down:
  - From cur 0, tone_freq=0x0100, glide_rate=0x30 -> cur_freq 0x30,0x60,0x90,0xC0,0xF0,0x100 (clamped on tick6), gliding drops after tick6.
  - Then tone_freq=0x0020 -> 0xD0,0xA0,0x70,0x40,0x20 (clamped).
- Sync latch: accumulator=0x123456, sync_in pulse with sample_en=0, strobe 3 clks later -> accumulator=0 after the strobe, sync_out stays 0, next strobe resumes adding. Also check sync_in coincident with a strobe -> same result, no residual pending.
- Hold: sample_en=0 for 10 clks while tone_freq changes 0x1000->0x2000 -> accumulator and cur_freq unchanged. Next strobe adds the old 0x1000 and cur_freq becomes 0x2000.
- Reset mid-glide with pending sync: rst for one clk -> accumulator=0, cur_freq=0, sync_out=0. The pending sync is discarded: the next strobe adds 0 and does not sync.
